inst_loader: RTL

//   Boot-time program loader. Takes the byte stream from the serial receiver and packs it into
//   32-bit instructions. Writes the words into inst_memory through a single-word write port.

---
 rtl/inst_loader.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/inst_loader.sv
// Boot-time program loader: packs a big-endian byte stream into 32-bit words and writes
// them into instruction memory. The stream starts with a 32-bit word count N.
module inst_loader #(
    parameter int INST_MEM_WIDTH = 2
) (
    input  logic                      CLK,
    input  logic                      reset,
    input  logic                      start,
    input  logic [7:0]                rx_data,
    input  logic                      rx_valid,
    output logic                      mem_we,
    output logic [INST_MEM_WIDTH-1:0] mem_addr,
    output logic [31:0]               mem_wdata,
    output logic                      busy,
    output logic                      done,
    output logic                      error
);

    localparam int              W        = INST_MEM_WIDTH;
    localparam logic [31:0]     CAPACITY = 32'd1 << W;
    localparam logic [W:0]      IDX_ONE  = {{W{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_BODY,
        S_DONE,
        S_ERROR
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    byte_cnt_q, byte_cnt_d;
    logic [W:0]    word_idx_q, word_idx_d;
    logic [23:0]   shift_q, shift_d;
    logic [W:0]    n_q, n_d;
    logic          last_q, last_d;
    logic          mem_we_q, mem_we_d;
    logic [W-1:0]  mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic [31:0]   assembled;

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        word_idx_d  = word_idx_q;
        shift_d     = shift_q;
        n_d         = n_q;
        last_d      = last_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        assembled   = {shift_q, rx_data};

        case (state_q)
            S_IDLE, S_ERROR: begin
                if (start) begin
                    state_d    = S_HEADER;
                    byte_cnt_d = 2'd0;
                    word_idx_d = '0;
                    shift_d    = '0;
                    last_d     = 1'b0;
                end
            end
            S_HEADER: begin
                if (rx_valid) begin
                    shift_d    = assembled[23:0];
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        n_d = assembled[W:0];
                        if (assembled == 32'd0) begin
                            state_d = S_DONE;
                        end else if (assembled > CAPACITY) begin
                            state_d = S_ERROR;
                        end else begin
                            state_d = S_BODY;
                        end
                    end
                end
            end
            S_BODY: begin
                // Stay in BODY through the final write cycle so busy covers it.
                if (last_q) begin
                    state_d = S_DONE;
                    last_d  = 1'b0;
                end else if (rx_valid) begin
                    shift_d    = assembled[23:0];
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = word_idx_q[W-1:0];
                        mem_wdata_d = assembled;
                        word_idx_d  = word_idx_q + IDX_ONE;
                        last_d      = (word_idx_q == n_q - IDX_ONE);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d  = (state_d == S_HEADER) || (state_d == S_BODY);
        done_d  = (state_d == S_DONE);
        error_d = (state_d == S_ERROR);
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q     <= S_IDLE;
            byte_cnt_q  <= 2'd0;
            word_idx_q  <= '0;
            shift_q     <= '0;
            n_q         <= '0;
            last_q      <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            word_idx_q  <= word_idx_d;
            shift_q     <= shift_d;
            n_q         <= n_d;
            last_q      <= last_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule
